e1_buf_wb_ram: RTL and testbench

Dual-port Wishbone responder that owns the E1 multiframe buffer memory. It serves the read and write cycles issued by the E1 buffer-to-Wishbone master on port A, and cycles from the host/SoC bus on port B. Both ports share one synchronous single-port RAM, arbitrated round-robin. All cycles are single-beat with byte write masks.

---
 rtl/e1_pkg.sv | 14 +
 rtl/e1_buf_ram.sv | 37 +++
 rtl/e1_buf_wb_ram.sv | 132 +++++++++++++
 tb/tb_e1_buf_wb_ram.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/e1_pkg.sv
// Shared definitions for the E1 multiframe buffer Wishbone RAM:
// FSM state encoding and arbiter port identifiers.
package e1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/e1_buf_ram.sv
// Single-port synchronous RAM, DW x 2^AW, per-byte active-low write mask,
// one-cycle registered read. Coded for FPGA SPRAM/EBR inference.
module e1_buf_ram #(
  parameter int DW = 32,
  parameter int MW = DW / 8,
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [MW-1:0] wmsk_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Contents and read register are deliberately not reset.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int unsigned i = 0; i < MW; i++) begin
          if (!wmsk_i[i]) begin
            mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/e1_buf_wb_ram.sv
// Dual-port single-beat Wishbone responder for the E1 multiframe buffer:
// round-robin arbitration of ports A and B onto one single-port RAM.
module e1_buf_wb_ram #(
  parameter int DW = 32,
  parameter int MW = DW / 8,
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic [MW-1:0] a_wmsk,
  input  logic          a_we,
  input  logic          a_cyc,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  input  logic [MW-1:0] b_wmsk,
  input  logic          b_we,
  input  logic          b_cyc,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata
);

  import e1_pkg::*;

  state_e        state_q;
  logic          prio_q;
  logic          port_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [MW-1:0] wmsk_q;
  logic          a_ack_q;
  logic          b_ack_q;
  logic [DW-1:0] a_hold_q;
  logic [DW-1:0] b_hold_q;

  logic          grant_d;
  logic          ram_en;
  logic [DW-1:0] ram_rdata;

  always_comb begin
    grant_d = PORT_A;
    if (a_cyc && b_cyc) begin
      grant_d = prio_q;
    end else if (b_cyc) begin
      grant_d = PORT_B;
    end
    ram_en = (state_q == ST_ACCESS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      prio_q   <= PORT_A;
      port_q   <= PORT_A;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmsk_q   <= '1;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      a_hold_q <= '0;
      b_hold_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (a_cyc || b_cyc) begin
            port_q <= grant_d;
            if (grant_d == PORT_B) begin
              addr_q  <= b_addr;
              wdata_q <= b_wdata;
              wmsk_q  <= b_wmsk;
              we_q    <= b_we;
            end else begin
              addr_q  <= a_addr;
              wdata_q <= a_wdata;
              wmsk_q  <= a_wmsk;
              we_q    <= a_we;
            end
            if (a_cyc && b_cyc) begin
              prio_q <= ~grant_d;
            end
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          a_ack_q <= (port_q == PORT_A);
          b_ack_q <= (port_q == PORT_B);
          state_q <= ST_ACK;
        end
        ST_ACK: begin
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          // Keep the last read word so rdata stays stable once ack drops.
          if (!we_q) begin
            if (port_q == PORT_A) begin
              a_hold_q <= ram_rdata;
            end else begin
              b_hold_q <= ram_rdata;
            end
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  e1_buf_ram #(
    .DW(DW),
    .MW(MW),
    .AW(AW)
  ) u_ram (
    .clk    (clk),
    .en_i   (ram_en),
    .we_i   (we_q),
    .addr_i (addr_q),
    .wdata_i(wdata_q),
    .wmsk_i (wmsk_q),
    .rdata_o(ram_rdata)
  );

  assign a_ack   = a_ack_q;
  assign b_ack   = b_ack_q;
  // The RAM read register is valid during ACK; the hold register covers other cycles.
  assign a_rdata = a_ack_q ? ram_rdata : a_hold_q;
  assign b_rdata = b_ack_q ? ram_rdata : b_hold_q;

endmodule

// File: tb/tb_e1_buf_wb_ram.sv
// Self-checking bench for e1_buf_wb_ram: directed cases plus randomized
// dual-port traffic checked against a word-level memory model.
module tb_e1_buf_wb_ram;

  localparam int DW = 32;
  localparam int MW = 4;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic [MW-1:0] a_wmsk, b_wmsk;
  logic          a_we, b_we, a_cyc, b_cyc;
  logic          a_ack, b_ack;
  logic [DW-1:0] a_rdata, b_rdata;

  int            vec_cnt = 0;
  int            err_cnt = 0;
  bit            overlap = 1'b0;
  logic [31:0]   mdl [int];

  always #5 clk = ~clk;

  e1_buf_wb_ram #(
    .DW(DW),
    .MW(MW),
    .AW(AW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .a_addr (a_addr),
    .a_wdata(a_wdata),
    .a_wmsk (a_wmsk),
    .a_we   (a_we),
    .a_cyc  (a_cyc),
    .a_ack  (a_ack),
    .a_rdata(a_rdata),
    .b_addr (b_addr),
    .b_wdata(b_wdata),
    .b_wmsk (b_wmsk),
    .b_we   (b_we),
    .b_cyc  (b_cyc),
    .b_ack  (b_ack),
    .b_rdata(b_rdata)
  );

  always @(negedge clk) if (a_ack && b_ack) overlap = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (!m[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // One master cycle on port p; latency counted in edges from raising cyc to seeing ack.
  task automatic txn(input bit p, input logic [AW-1:0] addr, input logic we,
                     input logic [31:0] wd, input logic [3:0] wm,
                     input int lo, input int hi, input string tag,
                     output logic [31:0] rd);
    int k;
    logic ack_s;
    @(posedge clk); #1;
    if (!p) begin
      a_addr = addr; a_we = we; a_wdata = wd; a_wmsk = wm; a_cyc = 1'b1;
    end else begin
      b_addr = addr; b_we = we; b_wdata = wd; b_wmsk = wm; b_cyc = 1'b1;
    end
    k = 0;
    ack_s = 1'b0;
    while (!ack_s && k < 20) begin
      @(posedge clk); #1;
      k++;
      ack_s = p ? b_ack : a_ack;
    end
    if (lo == hi) check({tag, "_lat"}, k, lo);
    else          check({tag, "_lat"}, {31'd0, (ack_s && k >= lo && k <= hi)}, 32'd1);
    rd = p ? b_rdata : a_rdata;
    if (we) begin
      if (!mdl.exists(int'(addr))) mdl[int'(addr)] = merge(32'hxxxx_xxxx, wd, wm);
      else mdl[int'(addr)] = merge(mdl[int'(addr)], wd, wm);
    end else if (mdl.exists(int'(addr))) begin
      check({tag, "_rd"}, rd, mdl[int'(addr)]);
    end
    @(posedge clk); #1;
    if (!p) a_cyc = 1'b0; else b_cyc = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int seen;
    rst = 1'b1;
    a_addr = '0; a_wdata = '0; a_wmsk = '0; a_we = 1'b0; a_cyc = 1'b0;
    b_addr = '0; b_wdata = '0; b_wmsk = '0; b_we = 1'b0; b_cyc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_ack", {31'd0, a_ack}, 32'd0);
    check("rst_b_ack", {31'd0, b_ack}, 32'd0);
    check("rst_a_rdata", a_rdata, 32'd0);
    check("rst_b_rdata", b_rdata, 32'd0);
    rst = 1'b0;

    // Basic write/read and byte-masked write
    txn(1'b0, 14'h0010, 1'b1, 32'hDEADBEEF, 4'b0000, 2, 2, "wr10", rd);
    txn(1'b0, 14'h0010, 1'b0, 32'h0, 4'h0, 2, 2, "rd10", rd);
    check("rd10_const", rd, 32'hDEADBEEF);
    txn(1'b0, 14'h0010, 1'b1, 32'h55555555, 4'b1101, 2, 2, "bwr10", rd);
    txn(1'b0, 14'h0010, 1'b0, 32'h0, 4'h0, 2, 2, "brd10", rd);
    check("brd10_const", rd, 32'hDEAD55EF);

    // Simultaneous requests, two rounds
    fork
      txn(1'b0, 14'h0020, 1'b1, 32'hA1A1A1A1, 4'h0, 2, 2, "simA1", rd);
      begin logic [31:0] r2; txn(1'b1, 14'h0021, 1'b1, 32'hB1B1B1B1, 4'h0, 5, 5, "simB1", r2); end
    join
    fork
      txn(1'b0, 14'h0020, 1'b0, 32'h0, 4'h0, 5, 5, "simA2", rd);
      begin logic [31:0] r2; txn(1'b1, 14'h0021, 1'b0, 32'h0, 4'h0, 2, 2, "simB2", r2); end
    join

    // Top address, no aliasing onto address 0
    txn(1'b0, 14'h3FFF, 1'b1, 32'h12345678, 4'h0, 2, 2, "wrtop", rd);
    txn(1'b0, 14'h0000, 1'b1, 32'h00000000, 4'h0, 2, 2, "wr0", rd);
    txn(1'b0, 14'h3FFF, 1'b0, 32'h0, 4'h0, 2, 2, "rdtop", rd);
    check("rdtop_const", rd, 32'h12345678);

    // Reset during ACCESS of a read
    @(posedge clk); #1;
    a_addr = 14'h0010; a_we = 1'b0; a_cyc = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstmid_ack", {31'd0, a_ack}, 32'd0);
    @(posedge clk); #1;
    check("rstmid_a_rdata", a_rdata, 32'd0);
    check("rstmid_b_rdata", b_rdata, 32'd0);
    a_cyc = 1'b0;
    rst = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (a_ack || b_ack) seen++;
    end
    check("rstmid_noack", seen, 0);
    txn(1'b0, 14'h0010, 1'b0, 32'h0, 4'h0, 2, 2, "rstrd", rd);
    check("rstrd_const", rd, 32'hDEAD55EF);
    check("b_rdata_hold", b_rdata, 32'd0);

    // Port B read while port A streams 8 writes
    fork
      for (int i = 0; i < 8; i++)
        txn(1'b0, 14'h0200 + 14'(i * 37), 1'b1, $urandom, 4'h0, 2, 5, "strA", rd);
      begin
        logic [31:0] r2;
        repeat (3) @(posedge clk);
        txn(1'b1, 14'h3FFF, 1'b0, 32'h0, 4'h0, 2, 5, "strB", r2);
      end
    join
    for (int i = 0; i < 8; i++)
      txn(1'b0, 14'h0200 + 14'(i * 37), 1'b0, 32'h0, 4'h0, 2, 2, "strRd", rd);

    // Randomized dual-port traffic on disjoint address pools
    for (int i = 0; i < 16; i++) begin
      txn(1'b0, 14'h0100 + 14'(i), 1'b1, $urandom, 4'h0, 2, 2, "fillA", rd);
      txn(1'b0, 14'h2100 + 14'(i), 1'b1, $urandom, 4'h0, 2, 2, "fillB", rd);
    end
    fork
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        txn(1'b0, 14'h0100 + 14'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            $urandom, 4'($urandom), 2, 5, "rndA", rd);
      end
      for (int j = 0; j < 30; j++) begin
        logic [31:0] r2;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        txn(1'b1, 14'h2100 + 14'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            $urandom, 4'($urandom), 2, 5, "rndB", r2);
      end
    join
    for (int i = 0; i < 16; i++) begin
      txn(1'b1, 14'h0100 + 14'(i), 1'b0, 32'h0, 4'h0, 2, 2, "finA", rd);
      txn(1'b0, 14'h2100 + 14'(i), 1'b0, 32'h0, 4'h0, 2, 2, "finB", rd);
    end

    check("ack_overlap", {31'd0, overlap}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
